counttest_checker: RTL
======================

Name: counttest_checker

Overview:
- Synthesizable RTL checker that sits directly downstream of counttest and observes its a, b, c stimulus lines.
- Checks the property "a |=> b ##1 c" with overlapping attempts and keeps pass, fail and vacuous-attempt counts in hardware.
- Pass and vacuous counting stay off for a warm-up window after reset, matching the assertion pass-off interval. Fail counting is never suppressed.
- Counts are visible to the bench and to silicon debug without simulator assertion support.

Parameters:
- CNT_W, 32, width of each count register; counts saturate at 2^CNT_W-1.
- PASS_OFF_CYCLES, 20, number of posedges after reset release during which passes and vacuous attempts are not counted.

Ports:
- clk  input  1  sampling clock, shared with counttest.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  attempt trigger.
- b  input  1  first consequent term.
- c  input  1  second consequent term.
- count_clr  input  1  synchronous clear of all count registers.
- pass_count  output  CNT_W  completed passes.
- fail_count  output  CNT_W  failures.
- vacuous_count  output  CNT_W  edges with a=0.
- pass_pulse  output  1  high for one cycle after each edge that resolves at least one counted pass.
- fail_pulse  output  1  high for one cycle after each edge that resolves at least one failure.
- pass_active  output  1  high once the warm-up window has elapsed.
- inflight  output  2  {s2, s1} pending-attempt stage flags.

Behaviour:
- Reset (rst_n=0, asynchronous): all count registers, pulses, s1, s2, the warm-up counter and pass_active go to 0. Any in-flight attempt is discarded and is never counted.
- Sampling: a, b and c are sampled at every posedge. Edge k is the k-th posedge after rst_n deasserts.
- Warm-up:
  - The warm-up counter increments up to PASS_OFF_CYCLES and then holds.
  - pass_active is registered and goes to 1 at edge PASS_OFF_CYCLES.
  - Passes and vacuous attempts resolved at edges with pass_active=0 (before that update) are dropped.
- Attempt pipeline, two stage flags:
  - s1 <= a.
  - s2 <= s1 & b.
- Resolution at each edge, evaluated from the pre-edge s1/s2 and the sampled b/c:
  - f1 = s1 & ~b.
  - f2 = s2 & ~c.
  - p = s2 & c.
  - v = ~a.
- Simultaneous events:
  - f1 and f2 can both occur in one edge; fail_count then increments by 2.
  - p and f1 can both occur in one edge; both are counted.
  - fail_pulse is high if f1|f2. pass_pulse is high if p and pass_active.
- Latency:
  - Attempt started at edge t: a fail on b resolves at t+1; a pass or a fail on c resolves at t+2.
  - Counts and pulses are updated at the resolving edge, so they are visible in the following cycle.
- Saturation: each count register holds at its maximum value. A +2 increment from max-1 saturates to max.
- count_clr:
  - Synchronous. At that edge all three count registers load 0, and that edge's increments are discarded.
  - s1, s2, the warm-up counter and pulses are unaffected; pulses still reflect that edge's resolutions.
- Mid-attempt reset: an assertion of rst_n while s1 or s2 is set produces no pass and no fail. Counting resumes from zero, and warm-up restarts.
- PASS_OFF_CYCLES=0: pass_active is 1 from reset release, and edge 1 counts normally.
- Structure: no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Warm-up suppression:
  - Stimulus: reset, then a=1, b=1, c=1 held for 30 edges, PASS_OFF_CYCLES=20.
  - Required: pass_active rises after edge 20; pass_count=10 after edge 30 (passes at edges 21..30); fail_count=0; vacuous_count=0.
- Early fail:
  - Stimulus: after warm-up, a=1 at edge t, b=0 at t+1.
  - Required: fail_pulse high for one cycle after t+1; fail_count=1; no pass.
- Double fail:
  - Stimulus: after warm-up, a=1 at edges t and t+1, b=1 at t+1, b=0 at t+2, c=0 at t+2.
  - Required: fail_count increments by 2 at edge t+2; single fail_pulse.
- Overlap pass plus fail:
  - Stimulus: a=1 at t and t+1, b=1 at t+1, c=1 and b=0 at t+2.
  - Required: pass_count+1 and fail_count+1 at edge t+2; both pulses high together.
- Reset mid-attempt and clear:
  - Stimulus: a=1 at edge t, rst_n=0 between t and t+1, release; then count_clr=1 on an edge with a pending pass.
  - Required: after the reset all counts are 0, pass_active=0 and s1=s2=0, with no pulse from the aborted attempt. The cleared edge leaves all counts at 0 while pass_pulse still asserts.
- Saturation:
  - Stimulus: CNT_W=3, drive 9 failures.
  - Required: fail_count holds at 7; pass_count is unchanged.

Source files
------------

// File: rtl/counttest_checker.sv
// ---------------------------------------------------------------------------
// counttest_checker
//
// Hardware checker for the property "a |=> b ##1 c" with overlapping
// attempts. It sits downstream of counttest, samples a/b/c on every posedge
// and keeps saturating pass, fail and vacuous-attempt counts. These counts are
// readable without simulator assertion support.
//
// Passes and vacuous attempts are ignored during a warm-up window of
// PASS_OFF_CYCLES edges after reset release. Failures are always counted.
//
// Ports:
//   clk           sampling clock (shared with counttest)
//   rst_n         asynchronous active-low reset
//   a, b, c       observed stimulus lines (trigger, 1st and 2nd consequent)
//   count_clr     synchronous clear of the three count registers
//   pass_count    completed passes (saturating, CNT_W bits)
//   fail_count    failures (saturating, CNT_W bits)
//   vacuous_count edges with a=0 (saturating, CNT_W bits)
//   pass_pulse    one-cycle flag: the previous edge resolved a counted pass
//   fail_pulse    one-cycle flag: the previous edge resolved a failure
//   pass_active   warm-up window has elapsed
//   inflight      {s2, s1} pending-attempt stage flags
// ---------------------------------------------------------------------------
module counttest_checker #(
    parameter int CNT_W           = 32,
    parameter int PASS_OFF_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             count_clr,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] vacuous_count,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic             pass_active,
    output logic [1:0]       inflight
);

    localparam int                WARM_W   = (PASS_OFF_CYCLES < 1) ? 1 : $clog2(PASS_OFF_CYCLES + 1);
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(PASS_OFF_CYCLES);
    // With no warm-up window the checker must count from the first edge, so
    // pass_active comes out of reset already set.
    localparam logic              ACTIVE_RST = (PASS_OFF_CYCLES == 0);

    // Saturating add of a 0..2 increment; all-ones is the ceiling, so a carry
    // out of the top bit means the true sum exceeded it.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
        if (sum[CNT_W]) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic              pass_active_q, pass_active_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]  vac_cnt_q, vac_cnt_d;
    logic              pass_pulse_q, pass_pulse_d;
    logic              fail_pulse_q, fail_pulse_d;

    logic       f1, f2, p, v;
    logic [1:0] fail_inc, pass_inc, vac_inc;

    always_comb begin
        // Resolution of attempts at this edge, from the pre-edge stage flags.
        f1 = s1_q & ~b;
        f2 = s2_q & ~c;
        p  = s2_q & c;
        v  = ~a;

        // f1 and f2 are independent attempts, so both may fail together.
        fail_inc = {f1 & f2, f1 ^ f2};
        pass_inc = {1'b0, p & pass_active_q};
        vac_inc  = {1'b0, v & pass_active_q};

        s1_d = a;
        s2_d = s1_q & b;

        warm_cnt_d = warm_cnt_q;
        if (warm_cnt_q != WARM_MAX) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
        end
        pass_active_d = (warm_cnt_d == WARM_MAX);

        if (count_clr) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            vac_cnt_d  = '0;
        end else begin
            pass_cnt_d = sat_add(pass_cnt_q, pass_inc);
            fail_cnt_d = sat_add(fail_cnt_q, fail_inc);
            vac_cnt_d  = sat_add(vac_cnt_q,  vac_inc);
        end

        // Pulses follow the resolutions even on a clearing edge.
        pass_pulse_d = p & pass_active_q;
        fail_pulse_d = f1 | f2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            warm_cnt_q    <= '0;
            pass_active_q <= ACTIVE_RST;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            vac_cnt_q     <= '0;
            pass_pulse_q  <= 1'b0;
            fail_pulse_q  <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            warm_cnt_q    <= warm_cnt_d;
            pass_active_q <= pass_active_d;
            pass_cnt_q    <= pass_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
            vac_cnt_q     <= vac_cnt_d;
            pass_pulse_q  <= pass_pulse_d;
            fail_pulse_q  <= fail_pulse_d;
        end
    end

    assign pass_count    = pass_cnt_q;
    assign fail_count    = fail_cnt_q;
    assign vacuous_count = vac_cnt_q;
    assign pass_pulse    = pass_pulse_q;
    assign fail_pulse    = fail_pulse_q;
    assign pass_active   = pass_active_q;
    assign inflight      = {s2_q, s1_q};

endmodule
